tile_rom_arbiter: RTL
=====================

# tile_rom_arbiter

Shares the single-port platform tile ROM (256 × 24-bit RGB, 16×16 tile, 1-cycle registered read) among up to four pixel requesters: background renderer, platform renderer, question-block renderer and debug overlay. Arbitration is round-robin. A grant may cover a short row burst of consecutive texels. Each returned texel is tagged with the requester ID, a last-of-burst flag and a colour-key (transparency) flag. The block sits between the renderers and the tile ROM instance in the top-level video path.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- KEY_COLOR, 24'hFF00FF, RGB value reported as transparent

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous, active-low reset
- req_i  in  N_REQ  per-requester request, held until granted
- x_i  in  4·N_REQ  start column per requester (packed, requester k at [4k+3:4k])
- y_i  in  4·N_REQ  row per requester
- len_i  in  4·N_REQ  burst length minus one (0 = 1 texel, 15 = 16 texels)
- gnt_o  out  N_REQ  one-hot grant pulse, one cycle
- rom_addr_o  out  8  ROM read address {y, x}, registered
- rom_data_i  in  24  ROM read data
- rsp_valid_o  out  1  texel valid
- rsp_id_o  out  $clog2(N_REQ)  requester owning the texel
- rsp_last_o  out  1  final texel of the burst
- rsp_data_o  out  24  texel RGB (equals rom_data_i)
- rsp_transparent_o  out  1  rsp_data_o == KEY_COLOR
- busy_o  out  1  state is BURST

## Operation
- Two states: IDLE and BURST.
- IDLE with any req_i set:
  - Pick the first set requester at or after rr_ptr (wrapping).
  - Assert gnt_o[k] combinationally in the same cycle.
  - At the edge, load rom_addr_o = {y_k, x_k}, cur_x = x_k + 1 (mod 16), cur_y = y_k, remaining = len_k, owner = k.
  - If len_k == 0: stay in IDLE, mark the issued slot last, set rr_ptr = k+1 (mod N_REQ).
  - Otherwise go to BURST.
- IDLE with no request: rom_addr_o holds its value and no slot is issued.
- BURST:
  - Each cycle issue rom_addr_o = {cur_y, cur_x}, increment cur_x (wraps 15→0 within the row, y never changes), decrement remaining.
  - When remaining == 1 at the edge: mark the slot last, return to IDLE, set rr_ptr = owner+1.
  - gnt_o is 0 throughout BURST. No pre-emption.
- A requester samples its inputs only in its grant cycle. It may drop or change req/x/y/len from the next cycle.
- Tag pipeline: s1 {valid, id, last} is registered with rom_addr_o. s2 is s1 delayed by one cycle, aligned with ROM data. rsp_valid_o, rsp_id_o and rsp_last_o come from s2.
- rsp_data_o and rsp_transparent_o are combinational from rom_data_i. Their values are meaningful only when rsp_valid_o is 1.
- Back-to-back: a new grant in IDLE is allowed in the cycle right after a burst's last issue, so throughput is one texel per cycle at full load.

## Timing
- Grant in cycle N → rom_addr_o valid in N+1 → rsp_valid_o with data in N+2. Latency is 2 cycles per texel.
- A burst of L+1 texels occupies the ROM for cycles N+1..N+L+1. Responses arrive in N+2..N+L+2, in address order.
- Reset values: state IDLE, rr_ptr 0, rom_addr_o 8'h00, s1/s2 valid 0, rsp_valid_o 0, rsp_last_o 0, rsp_id_o 0, gnt_o 0, busy_o 0.
- Reset asserted mid-burst:
  - The burst is aborted.
  - In-flight tags are cleared, so rsp_valid_o is 0 from the next cycle.
  - No partial-burst completion is reported.
- gnt_o is forced to 0 while Reset_n is low.
- Simultaneous requests: only one grant per cycle. Losers keep req_i high.

## Structure
- Package tile_rom_pkg holds:
  - TILE_DIM = 16, ADDR_W = 8, RGB_W = 24
  - the state enum {IDLE, BURST}
  - the default KEY_COLOR
  - the tag struct {valid, id, last}
- Sub-module rr_arbiter: parameterised N_REQ. Takes the req vector and rr_ptr, returns a one-hot grant plus an encoded index. It is purely combinational.
- The state machine, address generator and tag pipeline live in tile_rom_arbiter.

## Test plan
- After reset, req_i[0] with x=3, y=2, len=0 → gnt_o=0001 in cycle N; rom_addr_o=8'h23 in N+1; in N+2 rsp_valid_o=1, rsp_id_o=0, rsp_last_o=1, rsp_data_o=mem[8'h23].
- All four requesters asserted in the same cycle with len=0 → grants 0,1,2,3 on consecutive cycles; four responses in the same order starting 2 cycles after the first grant.
- req_i[1] with x=14, y=5, len=3 → addresses 5E, 5F, 50, 51; busy_o=1 for 3 cycles; rsp_last_o only on the 4th texel. req_i[2] raised mid-burst is granted in the cycle after the 51 issue.
- ROM word 24'hFF00FF at address 8'h00 → rsp_transparent_o=1. A neighbouring word 24'hFF00FE → 0.
- req_i[0] and req_i[3] held continuously with len=0 → grants alternate 0,3,0,3 (fairness, rr_ptr wrap).
- Reset_n low for one cycle during the 2nd texel of a len=7 burst → rsp_valid_o=0 and busy_o=0 next cycle, rom_addr_o=8'h00. The next request is served from rr_ptr=0.

Source files
------------

// File: rtl/tile_rom_pkg.sv
// Shared constants and types for the tile ROM arbiter.
// The tile ROM is 16x16 texels of 24-bit RGB, addressed as {y, x}.
package tile_rom_pkg;

  localparam int TILE_DIM = 16;
  localparam int ADDR_W   = 8;
  localparam int RGB_W    = 24;
  localparam int TAG_ID_W = 3;

  localparam logic [RGB_W-1:0] DEFAULT_KEY_COLOR = 24'hFF00FF;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                last;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
// Outputs a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset back to rr_ptr so the nearest hit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(rr_ptr) + off) % N_REQ);
      if (req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Round-robin sharing of the single-port tile ROM among pixel requesters,
// with row bursts and a two-stage tag pipeline aligned to the registered ROM read.
//
// state | meaning
// IDLE  | accepting a new grant; single-texel grants complete here
// BURST | issuing the remaining texels of a multi-texel row burst
module tile_rom_arbiter
  import tile_rom_pkg::*;
#(
  parameter  int               N_REQ     = 4,
  parameter  logic [RGB_W-1:0] KEY_COLOR = DEFAULT_KEY_COLOR,
  localparam int               IDX_W     = $clog2(N_REQ)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [4*N_REQ-1:0] x_i,
  input  logic [4*N_REQ-1:0] y_i,
  input  logic [4*N_REQ-1:0] len_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [ADDR_W-1:0]  rom_addr_o,
  input  logic [RGB_W-1:0]   rom_data_i,
  output logic               rsp_valid_o,
  output logic [IDX_W-1:0]   rsp_id_o,
  output logic               rsp_last_o,
  output logic [RGB_W-1:0]   rsp_data_o,
  output logic               rsp_transparent_o,
  output logic               busy_o
);

  state_e           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [3:0]       cur_x;
  logic [3:0]       cur_y;
  logic [3:0]       remaining;
  tag_t             s1;
  tag_t             s2;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  logic [3:0] x_arr   [N_REQ];
  logic [3:0] y_arr   [N_REQ];
  logic [3:0] len_arr [N_REQ];
  logic [3:0] sel_x;
  logic [3:0] sel_y;
  logic [3:0] sel_len;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] k);
    return (int'(k) == N_REQ - 1) ? '0 : k + 1'b1;
  endfunction

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      x_arr[k]   = x_i[4*k +: 4];
      y_arr[k]   = y_i[4*k +: 4];
      len_arr[k] = len_i[4*k +: 4];
    end
  end

  assign sel_x   = x_arr[arb_idx];
  assign sel_y   = y_arr[arb_idx];
  assign sel_len = len_arr[arb_idx];

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req     (req_i),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // Grant is visible in the same cycle the requester's fields are sampled.
  assign gnt_o = (Reset_n && state == IDLE) ? arb_gnt : '0;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      remaining  <= '0;
      rom_addr_o <= '0;
      s1         <= '0;
      s2         <= '0;
    end else begin
      s2 <= s1;
      s1 <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            rom_addr_o <= {sel_y, sel_x};
            cur_x      <= sel_x + 4'd1;
            cur_y      <= sel_y;
            remaining  <= sel_len;
            owner      <= arb_idx;
            s1         <= '{valid: 1'b1, id: TAG_ID_W'(arb_idx), last: (sel_len == 4'd0)};
            if (sel_len == 4'd0) begin
              rr_ptr <= wrap_inc(arb_idx);
            end else begin
              state <= BURST;
            end
          end
        end
        BURST: begin
          rom_addr_o <= {cur_y, cur_x};
          cur_x      <= cur_x + 4'd1;
          remaining  <= remaining - 4'd1;
          s1         <= '{valid: 1'b1, id: TAG_ID_W'(owner), last: (remaining == 4'd1)};
          if (remaining == 4'd1) begin
            state  <= IDLE;
            rr_ptr <= wrap_inc(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o            = (state == BURST);
  assign rsp_valid_o       = s2.valid;
  assign rsp_id_o          = s2.id[IDX_W-1:0];
  assign rsp_last_o        = s2.last;
  assign rsp_data_o        = rom_data_i;
  assign rsp_transparent_o = (rom_data_i == KEY_COLOR);

endmodule
